// File: rtl/ntt_mod_pkg.sv
// Shared NTT modulus definitions: datapath width and the prime table that
// the modular arithmetic units select from by index.
package ntt_mod_pkg;

    localparam int NTT_WIDTH  = 30;
    localparam int NUM_MODULI = 13;

    function automatic logic [NTT_WIDTH-1:0] prime_at(input int idx);
        logic [NTT_WIDTH-1:0] p;
        case (idx)
            0:       p = 30'd1063321601;
            1:       p = 30'd1063452673;
            2:       p = 30'd1064697857;
            3:       p = 30'd1065484289;
            4:       p = 30'd1065811969;
            5:       p = 30'd1068236801;
            6:       p = 30'd1068433409;
            7:       p = 30'd1068564481;
            8:       p = 30'd1069219841;
            9:       p = 30'd1070727169;
            10:      p = 30'd1071513601;
            11:      p = 30'd1072496641;
            12:      p = 30'd1073479681;
            default: p = 30'd1063321601;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/subtract pipeline: stage 1 forms the raw and
// corrected candidates, stage 2 picks the reduced one.
module mod_addsub_lane
    import ntt_mod_pkg::*;
#(
    parameter int WIDTH = NTT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load1,
    input  logic             load2,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH:0]   a_ext, b_ext, raw_next;
    logic [WIDTH-1:0] corr_next;
    logic [WIDTH:0]   raw_reg;
    logic [WIDTH-1:0] corr_reg;
    logic             op_reg;
    logic             sel_corr;
    logic [WIDTH-1:0] c_reg;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // The correction only needs WIDTH bits: a wrapped subtraction plus q and
    // an oversized sum minus q both land back in [0, q) modulo 2^WIDTH.
    always_comb begin
        raw_next  = '0;
        corr_next = '0;
        if (op) begin
            raw_next  = a_ext - b_ext;
            corr_next = raw_next[WIDTH-1:0] + q;
        end else begin
            raw_next  = a_ext + b_ext;
            corr_next = raw_next[WIDTH-1:0] - q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_reg  <= '0;
            corr_reg <= '0;
            op_reg   <= 1'b0;
        end else if (load1) begin
            raw_reg  <= raw_next;
            corr_reg <= corr_next;
            op_reg   <= op;
        end
    end

    // raw_reg[WIDTH] is the borrow of a subtraction.
    assign sel_corr = op_reg ? raw_reg[WIDTH] : (raw_reg >= {1'b0, q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg <= '0;
        end else if (load2) begin
            c_reg <= sel_corr ? corr_reg : raw_reg[WIDTH-1:0];
        end
    end

    assign c = c_reg;

endmodule

// File: rtl/modular_add_sub_pipe.sv
// Multi-lane two-stage modular adder/subtractor with valid/ready flow control
// and a modulus-load path that only fires while the pipeline is empty.
module modular_add_sub_pipe #(
    parameter int WIDTH      = ntt_mod_pkg::NTT_WIDTH,
    parameter int LANES      = 2,
    parameter int NUM_MODULI = ntt_mod_pkg::NUM_MODULI,
    parameter int IDX_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mod_sel,
    input  logic [IDX_W-1:0]       mod_index,
    output logic                   mod_ready,
    output logic                   mod_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] c,
    output logic                   range_err
);

    import ntt_mod_pkg::*;

    localparam logic [IDX_W:0] NUM_MOD_BOUND = (IDX_W+1)'(NUM_MODULI);

    logic             s1_valid_reg, s2_valid_reg;
    logic             mod_err_reg, range_err_reg;
    logic [WIDTH-1:0] q_reg;
    logic             advance1, accept, stage2_load, mod_load, idx_ok;
    logic [LANES-1:0] lane_range;

    assign advance1    = !s2_valid_reg || out_ready;
    assign in_ready    = !mod_sel && (!s1_valid_reg || advance1);
    assign accept      = in_valid && in_ready;
    assign stage2_load = s1_valid_reg && advance1;
    assign mod_ready   = !s1_valid_reg && !s2_valid_reg;
    assign mod_load    = mod_sel && mod_ready;
    assign idx_ok      = ({1'b0, mod_index} < NUM_MOD_BOUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            q_reg         <= WIDTH'(prime_at(0));
            mod_err_reg   <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            if (accept)
                s1_valid_reg <= 1'b1;
            else if (advance1)
                s1_valid_reg <= 1'b0;
            if (advance1)
                s2_valid_reg <= s1_valid_reg;
            if (mod_load && idx_ok)
                q_reg <= WIDTH'(prime_at(int'(mod_index)));
            mod_err_reg   <= mod_load && !idx_ok;
            range_err_reg <= range_err_reg || (accept && (|lane_range));
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_range[gi] = (a[gi*WIDTH +: WIDTH] >= q_reg) ||
                                    (b[gi*WIDTH +: WIDTH] >= q_reg);

            mod_addsub_lane #(
                .WIDTH(WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .load1 (accept),
                .load2 (stage2_load),
                .op    (op[gi]),
                .a     (a[gi*WIDTH +: WIDTH]),
                .b     (b[gi*WIDTH +: WIDTH]),
                .q     (q_reg),
                .c     (c[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign out_valid = s2_valid_reg;
    assign mod_err   = mod_err_reg;
    assign range_err = range_err_reg;

endmodule

// File: tb/tb_modular_add_sub_pipe.sv
// Directed-vector bench for modular_add_sub_pipe with hand-computed results.
module tb_modular_add_sub_pipe;

    localparam int W = 30;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mod_sel = 1'b0;
    logic [3:0]     mod_index = '0;
    logic           mod_ready, mod_err;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [L-1:0]   op = '0;
    logic [L*W-1:0] a = '0;
    logic [L*W-1:0] b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [L*W-1:0] c;
    logic           range_err;

    int checks = 0;
    int errors = 0;

    int unsigned primes [13] = '{1063321601, 1063452673, 1064697857, 1065484289,
                                 1065811969, 1068236801, 1068433409, 1068564481,
                                 1069219841, 1070727169, 1071513601, 1072496641,
                                 1073479681};

    modular_add_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mod_sel   (mod_sel),
        .mod_index (mod_index),
        .mod_ready (mod_ready),
        .mod_err   (mod_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_mod(input logic [3:0] idx, output logic err_seen);
        int n;
        n = 0;
        @(negedge clk);
        mod_sel = 1'b1;
        mod_index = idx;
        #1;
        while (!mod_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_val("mod_ready_timeout", 0, 1);
        @(negedge clk);
        mod_sel = 1'b0;
        #1;
        err_seen = mod_err;
        $display("load index %0d err=%0b", idx, err_seen);
    endtask

    task automatic run_beat(input logic [L-1:0] op_v, input logic [L*W-1:0] a_v,
                            input logic [L*W-1:0] b_v, output logic [L*W-1:0] c_v,
                            output int lat);
        int n;
        @(negedge clk);
        op = op_v;
        a = a_v;
        b = b_v;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_val("beat_accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check_val("beat_result_timeout", 0, 1);
        c_v = c;
        $display("beat op=%b a=%h b=%h c=%h lat=%0d", op_v, a_v, b_v, c_v, lat);
    endtask

    logic [L*W-1:0] res;
    logic           err;
    int             lat;
    int             sent, got;
    int unsigned    st_exp0 [3] = '{15, 16, 17};
    int unsigned    st_exp1 [3] = '{4, 3, 2};

    initial begin
        // reset state
        #12;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_c", c, 0);
        check_val("rst_mod_err", mod_err, 0);
        check_val("rst_range_err", range_err, 0);
        check_val("rst_mod_ready", mod_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // index 0 without a load: reset modulus, latency 2
        run_beat(2'b01, {30'd100, 30'd9354}, {30'd23, 30'd1239384}, res, lat);
        check_val("idx0_latency", lat, 2);
        check_val("idx0_sub_lane0", res[W-1:0], 1062091571);
        check_val("idx0_add_lane1", res[2*W-1:W], 123);

        // wrap-around subtraction and doubled addition at every index
        for (int i = 0; i < 13; i++) begin
            load_mod(4'(i), err);
            check_val("load_err_valid_idx", err, 0);
            run_beat(2'b01, {30'(primes[i] - 1), 30'd1}, {30'(primes[i] - 1), 30'(primes[i] - 1)}, res, lat);
            check_val("sub_all_idx_lane0", res[W-1:0], 2);
            check_val("add_all_idx_lane1", res[2*W-1:W], 64'(primes[i] - 2));
        end

        // index 12 boundaries
        run_beat(2'b00, {30'd0, 30'd1073479680}, {30'd0, 30'd1}, res, lat);
        check_val("idx12_add_to_q", res, 0);
        run_beat(2'b01, '0, '0, res, lat);
        check_val("zero_mixed_01", res, 0);
        run_beat(2'b10, '0, '0, res, lat);
        check_val("zero_mixed_10", res, 0);

        // deferred load with bad index while a beat is stalled in flight
        @(negedge clk);
        op = 2'b00;
        a = {30'd5, 30'(primes[12] - 1)};
        b = {30'd7, 30'd1};
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        check_val("defer_accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        mod_sel = 1'b1;
        mod_index = 4'd13;
        #1;
        check_val("defer_mod_ready_s1", mod_ready, 0);
        check_val("defer_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check_val("defer_mod_ready_s2", mod_ready, 0);
        check_val("defer_no_err", mod_err, 0);
        check_val("defer_out_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_val("defer_result", c, {30'd12, 30'd0});
        @(negedge clk);
        #1;
        check_val("defer_mod_ready_drained", mod_ready, 1);
        check_val("defer_err_before_load", mod_err, 0);
        @(negedge clk);
        mod_sel = 1'b0;
        #1;
        check_val("bad_idx_err_pulse", mod_err, 1);
        @(negedge clk);
        #1;
        check_val("bad_idx_err_clears", mod_err, 0);
        run_beat(2'b00, {30'd0, 30'(primes[12] - 1)}, {30'd0, 30'd1}, res, lat);
        check_val("q_kept_after_bad_idx", res, 0);

        // back-to-back beats with out_ready low for three cycles
        load_mod(4'd0, err);
        check_val("load0_err", err, 0);
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            if (sent < 3) begin
                op = 2'b10;
                a = {30'd5, 30'(10 + sent)};
                b = {30'(sent + 1), 30'd5};
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) check_val("stall_in_ready_low", in_ready, 0);
            if (cyc >= 2 && cyc <= 4) begin
                check_val("stall_out_valid_hold", out_valid, 1);
                check_val("stall_c_hold", c, {30'd4, 30'd15});
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check_val("stall_lane0_order", c[W-1:0], 64'(st_exp0[got]));
                check_val("stall_lane1_order", c[2*W-1:W], 64'(st_exp1[got]));
                $display("stall beat %0d out c=%h", got, c);
                got++;
            end
        end
        check_val("stall_all_out", got, 3);
        @(negedge clk);
        in_valid = 1'b0;

        // sticky range error
        #1;
        check_val("range_err_clear", range_err, 0);
        run_beat(2'b00, {30'd0, 30'(primes[0])}, '0, res, lat);
        check_val("range_a_eq_q_result", res, 0);
        check_val("range_err_set", range_err, 1);
        run_beat(2'b00, {30'd1, 30'd2}, {30'd3, 30'd4}, res, lat);
        check_val("range_inrange_result", res, {30'd4, 30'd6});
        check_val("range_err_sticky", range_err, 1);

        // reset mid-stream discards the in-flight beat and restores table[0]
        load_mod(4'd7, err);
        check_val("load7_err", err, 0);
        @(negedge clk);
        op = 2'b00;
        a = {30'd0, 30'd5};
        b = {30'd0, 30'd6};
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_val("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_range_err", range_err, 0);
        check_val("midrst_c", c, 0);
        check_val("midrst_mod_ready", mod_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_beat(2'b01, {30'd0, 30'd1}, {30'd0, 30'd1063321600}, res, lat);
        check_val("post_rst_q0", res[W-1:0], 2);
        check_val("post_rst_range_err", range_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/modular_add_sub_pipe.md
Name: modular_add_sub_pipe

Overview:
- Multi-lane, pipelined modular adder/subtractor for the NTT datapath.
- Generalises the single-lane subtract-only unit: configurable width and lane count, per-lane add/sub mode, valid/ready flow control with stall, and a guarded modulus-load path.
- The modulus is selected by index from the shared NTT prime table.
- Sits between the butterfly multiplier outputs and the coefficient memory write-back.

Parameters:
- WIDTH, 30, operand/modulus bit width.
- LANES, 2, number of independent parallel lanes sharing one modulus.
- NUM_MODULI, 13, number of valid entries in the prime table.
- IDX_W, 4, width of the modulus index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mod_sel  in  1  request to load the modulus selected by mod_index.
- mod_index  in  IDX_W  prime-table index.
- mod_ready  out  1  high when a modulus load is accepted (pipeline empty).
- mod_err  out  1  one-cycle pulse: load requested with mod_index >= NUM_MODULI.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat.
- op  in  LANES  per-lane mode: 0 = add, 1 = subtract.
- a  in  LANES*WIDTH  lane-packed minuend/addend; lane k occupies bits [k*WIDTH +: WIDTH].
- b  in  LANES*WIDTH  lane-packed subtrahend/addend.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- c  out  LANES*WIDTH  lane-packed results.
- range_err  out  1  sticky flag: some accepted operand was >= q.

Behaviour:
- Reset (async, rst_n = 0):
  - q register = table[0]; all pipeline valid bits = 0.
  - c = 0, out_valid = 0, mod_err = 0, range_err = 0.
- Modulus load:
  - mod_ready = 1 iff both stage valid bits are 0.
  - Load occurs on an edge with mod_sel && mod_ready.
  - If index < NUM_MODULI: q <= table[index]; usable by a beat accepted on the next cycle.
  - Otherwise q is unchanged and mod_err pulses for 1 cycle.
  - mod_sel while not mod_ready: ignored, no error; the requester holds mod_sel.
- Input acceptance:
  - in_ready = !mod_sel && (!s1_valid || advance1).
  - advance1 = !s2_valid || out_ready.
  - If mod_sel and in_valid are high in the same cycle, the load takes priority and in_ready = 0.
- Pipeline: 2 stages, latency 2 cycles from accept to out_valid when unstalled; throughput 1 beat/cycle.
  - Stage 1, per lane:
    - raw = a + b for add, a - b for sub, computed at WIDTH+1 bits.
    - corr = raw - q for add, raw + q for sub.
    - Registers raw, corr, the sign/borrow bit, and op.
  - Stage 2:
    - Add: c = (raw >= q) ? corr : raw.
    - Sub: c = borrow ? corr : raw.
    - Result is always in [0, q-1] when a, b < q.
- Stall:
  - When out_valid && !out_ready, c and out_valid hold; stage 1 holds if full.
  - No beat is lost or duplicated.
- range_err:
  - Set when an accepted beat has any lane with a >= q or b >= q; cleared only by reset.
  - The result for that lane is still raw/corr selected, but is not guaranteed reduced.
- Lanes are fully independent except for the shared q; mixed op values within one beat are legal.
- Reset mid-operation discards in-flight beats immediately.

Decomposition:
- Package ntt_mod_pkg holds:
  - NTT_WIDTH = 30, NUM_MODULI = 13.
  - Prime table, q[0..12]: 1063321601, 1063452673, 1064697857, 1065484289, 1065811969, 1068236801, 1068433409, 1068564481, 1069219841, 1070727169, 1071513601, 1072496641, 1073479681.
- One sub-module, mod_addsub_lane: the per-lane stage-1 and stage-2 datapath with an enable input, instantiated LANES times. Control and modulus logic stay in the top.

Test Plan:
- Sub at every index: load index i; for lane 0 drive op=1, a=1, b=q_i-1 -> c=2 after 2 cycles. Index 0: b=1063321600 -> c=2.
- Index 0, sub, a=9354, b=1239384 -> c=1062091571. Same beat, lane 1 add a=100, b=23 -> c=123.
- Index 12, add, a=1073479680, b=1 -> c=0. Then a=0, b=0 in both modes -> c=0.
- Back-to-back beats with out_ready held low for 3 cycles:
  - in_ready drops after 2 beats are buffered.
  - Results emerge in order, unchanged, once out_ready rises.
- mod_sel asserted while beats are in flight:
  - mod_ready = 0 and the load is deferred until the pipeline drains.
  - mod_index=13 -> mod_err pulses 1 cycle and q stays at its previous value.
- Accepted beat with a = q_0 -> range_err goes to 1 and stays set. Assert rst_n low mid-stream -> out_valid = 0, range_err = 0, and q = 1063321601.
